// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port cache-to-memory arbiter:
// default widths, FSM state encoding and the round-robin pick helper.
package mem_arbiter_pkg;

  localparam int ADDR_W_DEF = 28;
  localparam int DATA_W_DEF = 128;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GRANT_I = 2'b01,
    GRANT_D = 2'b10
  } arb_state_e;

  // On a tie the port that did not win last time gets the grant.
  function automatic arb_state_e arb_pick(input logic i_req, input logic d_req, input logic last_d);
    arb_state_e pick;
    if (i_req && d_req) begin
      pick = last_d ? GRANT_I : GRANT_D;
    end else if (d_req) begin
      pick = GRANT_D;
    end else if (i_req) begin
      pick = GRANT_I;
    end else begin
      pick = IDLE;
    end
    return pick;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Shared-memory side of the arbiter: command/address/data out, data/ready back.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              rd;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ready;

  modport master (output rd, wr, addr, wdata, input rdata, ready);
  modport slave  (input rd, wr, addr, wdata, output rdata, ready);
endinterface

// File: rtl/mem_arbiter_rdata_hold.sv
// Per-port read-data hold register with a same-cycle bypass of memory data
// while that port's ready pulse is high.
module arb_rdata_hold
  import mem_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              capture_i,
  input  logic              bypass_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] hold_d;
  logic [DATA_W-1:0] hold_q;

  // Next hold value: only a completed read replaces it.
  always_comb begin
    hold_d = hold_q;
    if (capture_i) begin
      hold_d = mem_rdata_i;
    end else begin
      hold_d = hold_q;
    end
  end

  // Hold register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= {DATA_W{1'b0}};
    end else begin
      hold_q <= hold_d;
    end
  end

  assign rdata_o = bypass_i ? mem_rdata_i : hold_q;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one block-memory port between the instruction
// cache (read only) and the data cache (read / write-back).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              proc_reset_n,
  input  logic              i_mem_read,
  input  logic [ADDR_W-1:0] i_mem_addr,
  output logic [DATA_W-1:0] i_mem_rdata,
  output logic              i_mem_ready,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_addr,
  input  logic [DATA_W-1:0] d_mem_wdata,
  output logic [DATA_W-1:0] d_mem_rdata,
  output logic              d_mem_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  arb_state_e state_d, state_q;
  logic       last_d_d, last_d_q;
  logic       i_req, d_req;
  logic       i_capture, d_capture;

  assign i_req = i_mem_read;
  assign d_req = d_mem_read | d_mem_write;

  // Grant FSM and memory-side muxing; a dropped request aborts the grant.
  always_comb begin
    state_d     = state_q;
    last_d_d    = last_d_q;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_addr    = {ADDR_W{1'b0}};
    mem_wdata   = {DATA_W{1'b0}};
    i_mem_ready = 1'b0;
    d_mem_ready = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = arb_pick(i_req, d_req, last_d_q);
      end
      GRANT_I: begin
        mem_read    = i_mem_read;
        mem_addr    = i_mem_addr;
        i_mem_ready = mem_ready;
        if (mem_ready) begin
          state_d  = IDLE;
          last_d_d = 1'b0;
        end else if (!i_req) begin
          state_d = IDLE;
        end else begin
          state_d = GRANT_I;
        end
      end
      GRANT_D: begin
        // A write-back wins when the data cache raises both commands.
        mem_write   = d_mem_write;
        mem_read    = d_mem_read & ~d_mem_write;
        mem_addr    = d_mem_addr;
        mem_wdata   = d_mem_wdata;
        d_mem_ready = mem_ready;
        if (mem_ready) begin
          state_d  = IDLE;
          last_d_d = 1'b1;
        end else if (!d_req) begin
          state_d = IDLE;
        end else begin
          state_d = GRANT_D;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and round-robin flag.
  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      state_q  <= IDLE;
      last_d_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
    end
  end

  assign i_capture = (state_q == GRANT_I) && mem_ready && i_mem_read;
  assign d_capture = (state_q == GRANT_D) && mem_ready && d_mem_read && !d_mem_write;

  arb_rdata_hold #(.DATA_W(DATA_W)) u_hold_i (
    .clk         (clk),
    .rst_n       (proc_reset_n),
    .capture_i   (i_capture),
    .bypass_i    (i_mem_ready),
    .mem_rdata_i (mem_rdata),
    .rdata_o     (i_mem_rdata)
  );

  arb_rdata_hold #(.DATA_W(DATA_W)) u_hold_d (
    .clk         (clk),
    .rst_n       (proc_reset_n),
    .capture_i   (d_capture),
    .bypass_i    (d_mem_ready),
    .mem_rdata_i (mem_rdata),
    .rdata_o     (d_mem_rdata)
  );

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 28, memory block address width.
REQ-002 SHALL have parameter DATA_W, default 128, memory block (4-word) data width.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on posedge clk.
REQ-004 SHALL have port proc_reset_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port i_mem_read  input  1  instruction-cache block read request, held until i_mem_ready.
REQ-006 SHALL have port i_mem_addr  input  ADDR_W  instruction-cache block address.
REQ-007 SHALL have port i_mem_rdata  output  DATA_W  block returned to the instruction cache.
REQ-008 SHALL have port i_mem_ready  output  1  one-cycle completion pulse to the instruction cache.
REQ-009 SHALL have port d_mem_read  input  1  data-cache block read request.
REQ-010 SHALL have port d_mem_write  input  1  data-cache block write-back request.
REQ-011 SHALL have port d_mem_addr  input  ADDR_W  data-cache block address.
REQ-012 SHALL have port d_mem_wdata  input  DATA_W  data-cache write-back block.
REQ-013 SHALL have port d_mem_rdata  output  DATA_W  block returned to the data cache.
REQ-014 SHALL have port d_mem_ready  output  1  one-cycle completion pulse to the data cache.
REQ-015 SHALL have ports mem_read, mem_write  output  1 each  shared memory commands.
REQ-016 SHALL have ports mem_addr  output  ADDR_W  and  mem_wdata  output  DATA_W  to shared memory.
REQ-017 SHALL have ports mem_rdata  input  DATA_W  and  mem_ready  input  1  from shared memory.

Function
REQ-018 SHALL implement states IDLE, GRANT_I, GRANT_D; IDLE drives all mem_* outputs to 0.
REQ-019 In IDLE, a request (i_mem_read, or d_mem_read|d_mem_write) SHALL move the FSM to the matching GRANT state at the next edge; arbitration latency is one cycle.
REQ-020 On simultaneous I and D requests in IDLE, the grant SHALL go to the port not granted last (round-robin flag last_d; reset value 0, so D wins the first tie).
REQ-021 In GRANT_I, the block SHALL drive mem_read=i_mem_read, mem_addr=i_mem_addr, mem_write=0, mem_wdata=0.
REQ-022 In GRANT_D, the block SHALL pass d_mem_read, d_mem_write, d_mem_addr and d_mem_wdata to memory; if both read and write are high, mem_write=1 and mem_read=0.
REQ-023 In a GRANT state, mem_ready SHALL be forwarded combinationally to the granted port's ready output only; the other ready output SHALL stay 0.
REQ-024 On the mem_ready edge, the block SHALL capture mem_rdata into the granted port's hold register, return to IDLE, and update last_d.
REQ-025 The x_mem_rdata output SHALL equal mem_rdata while x_mem_ready=1, and SHALL otherwise equal the hold register, which stays stable until that port's next completed read.
REQ-026 A write completion SHALL NOT update d_mem_rdata's hold register.
REQ-027 If the granted port drops all of its requests before mem_ready, the block SHALL return to IDLE next edge without a ready pulse (abort).
REQ-028 A request arriving in the mem_ready cycle SHALL be arbitrated in IDLE the following cycle, so back-to-back transactions are separated by one idle cycle.

Reset
REQ-029 When proc_reset_n=0, the block SHALL asynchronously force state=IDLE, last_d=0 and both hold registers=0.
REQ-030 During reset, all outputs SHALL be 0, including mem_read, mem_write, both ready pulses and both rdata outputs.
REQ-031 Reset asserted mid-transaction SHALL abandon the transaction; no ready pulse SHALL be produced for it after release.

Structure
REQ-032 A shared package SHALL hold ADDR_W/DATA_W defaults and the arbiter state encoding (IDLE=2'b00, GRANT_I=2'b01, GRANT_D=2'b10).
REQ-033 The per-port rdata hold register and bypass mux SHALL be one sub-module, arb_rdata_hold, instantiated twice.
REQ-034 The FSM and round-robin flag SHALL reside in mem_arbiter.

Verification
REQ-035 I read only, addr 0x0000010, memory ready after 3 cycles with data 0xA5..A5 -> mem_read=1 for exactly those cycles, one i_mem_ready pulse, i_mem_rdata=0xA5..A5 held afterward, d_mem_ready never asserted.
REQ-036 I read and D read both asserted in the first cycle after reset -> D granted first, I granted after D's mem_ready plus one idle cycle.
REQ-037 D write, addr 0x0000020, wdata 0x1234..., followed by D read, addr 0x0000040 -> mem_write then mem_read with the correct addresses; d_mem_rdata changes only after the read.
REQ-038 Continuous I and D requests over 6 transactions -> grants alternate D,I,D,I,D,I.
REQ-039 proc_reset_n pulsed low during GRANT_I -> all outputs 0 immediately, no i_mem_ready afterward, FSM in IDLE.
REQ-040 D request withdrawn before mem_ready -> FSM in IDLE next cycle, no ready pulse, hold register unchanged.
